pwm_breather: RTL and testbench
===============================

Name: pwm_breather

Overview:
- Downstream consumer of the free-running 16-bit `currentCount` bus that also feeds the blinker.
- Produces a "breathing" LED drive. The 8-bit duty ramps up, holds, ramps down and holds, stepping on rising edges of a selected count bit.
- The duty is compared against the low count bits to generate PWM.
- Output drives a dedicated `uo_out` bit in the top-level wrapper.

Parameters:
- CNT_W, 16, width of `currentCount`.
- DUTY_W, 8, duty width. PWM compares against `currentCount[DUTY_W-1:0]`.
- STEP_BIT, 11, index of the count bit whose rising edge is one ramp step.
- HOLD_STEPS, 32, number of step ticks spent in each hold phase (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  design enable. Low freezes sequencing and forces PWM off.
- currentCount  in  CNT_W  shared free-running count.
- pwm_out  out  1  registered PWM drive.
- duty  out  DUTY_W  current raw duty value.
- phase  out  2  FSM state: 00 UP, 01 TOP, 10 DOWN, 11 BOT.
- ramp_done  out  1  one-cycle pulse at the end of each full breath.

Behaviour:
- One clock (`clk`); reset is synchronous and active-high (`rst`). All state updates on the rising `clk` edge.
- Reset values:
  - `pwm_out` = 0, `duty` = 0, `phase` = UP, `ramp_done` = 0, hold counter = 0.
  - While `rst` is high, the edge register loads `currentCount[STEP_BIT]`, so no spurious tick occurs after release.
- Tick:
  - tick = `currentCount[STEP_BIT]` & ~prev; prev <= `currentCount[STEP_BIT]` every cycle, including while `ena` = 0.
  - A falling bit (for example, the upstream counter resetting to 0) never produces a tick.
- FSM: transitions only when tick & `ena`.
  - UP: `duty` += 1. On the tick where `duty` == 254, `duty` becomes 255, go to TOP, clear hold.
  - TOP: hold += 1. On the tick where hold == HOLD_STEPS-1, go to DOWN, clear hold.
  - DOWN: `duty` -= 1. On the tick where `duty` == 1, `duty` becomes 0, go to BOT, clear hold.
  - BOT: hold += 1. On the tick where hold == HOLD_STEPS-1, go to UP, clear hold, assert `ramp_done` for exactly that one cycle.
  - `duty` saturates at 0 and 255 and never wraps.
- PWM: `pwm_out` <= `ena` & (`currentCount[DUTY_W-1:0]` < eff_duty).
  - One-cycle latency from `currentCount`.
  - eff_duty = `duty` (see Optional Feature).
  - `duty` 0 gives constant 0; `duty` 255 gives high for 255 of 256 counts.
- `ena` low:
  - FSM, `duty` and hold counter are frozen.
  - `pwm_out` is 0 from the next edge; `ramp_done` is 0.
  - On re-enable, the first tick is the next genuine rising edge.
- `rst` mid-operation: all state returns to reset values on that edge, regardless of `ena` or tick.
- `rst` and tick in the same cycle: reset wins.

Optional Feature:
- Macro `PWM_BREATHER_GAMMA_EN`.
- Defined: eff_duty = (`duty`*`duty`)>>8 (16-bit product, upper 8 bits), computed combinationally.
  - Perceptual gamma; `duty` 255 gives eff 254, `duty` 15 gives eff 0.
  - PWM latency unchanged.
- Undefined: eff_duty = `duty`; no multiplier is synthesized.
- `duty` output always shows the raw value.

Decomposition:
- Shared package `breather_pkg`:
  - phase encoding constants PH_UP/PH_TOP/PH_DOWN/PH_BOT (2-bit);
  - DUTY_MAX = 255;
  - default CNT_W/DUTY_W.
- One natural sub-module: `rise_tick` (edge register plus tick, with the load-on-reset rule), reusable by other count-bit consumers.

Test Plan:
- Reset:
  - Stimulus: hold `rst` for 3 cycles with `currentCount` = 16'h0FFF, then release with bit 11 still high.
  - Required: all outputs 0 and `phase` 00 during reset; no tick and `duty` 0 for the following cycles.
- PWM:
  - Stimulus: STEP_BIT=3, free-running `currentCount`, 10 ticks.
  - Required: `duty` = 10; `pwm_out` high exactly on counts 0..9 of each 256-count period, one cycle delayed.
- Full breath:
  - Stimulus: STEP_BIT=3, HOLD_STEPS=4.
  - Required: 255 UP ticks to `duty` 255, 4 TOP ticks, 255 DOWN ticks to 0, 4 BOT ticks; `ramp_done` high exactly 1 cycle; `phase` back to 00; no wrap past 255 or 0.
- Enable freeze:
  - Stimulus: drop `ena` at `duty` 100 for 50 tick periods, re-enable while the step bit is high.
  - Required: `duty` stays 100, `pwm_out` 0 throughout; no immediate tick; next rising edge gives `duty` 101.
- Upstream counter reset:
  - Stimulus: force `currentCount` from 16'h0808 to 0, then resume counting.
  - Required: no tick on the drop; `duty` unchanged until the next genuine rising edge of the step bit.
- `PWM_BREATHER_GAMMA_EN` defined:
  - Stimulus: run to `duty` 128, then to `duty` 255.
  - Required: at `duty` 128, `pwm_out` high 64/256 counts; at `duty` 255, high 254/256 counts; `duty` output reads raw 128/255.

Source files
------------

// File: rtl/breather_pkg.sv
// rtl/breather_pkg.sv - shared constants for currentCount consumers
package breather_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int DUTY_W_DEF = 8;
    localparam int DUTY_MAX   = 255;

    localparam logic [1:0] PH_UP   = 2'b00;
    localparam logic [1:0] PH_TOP  = 2'b01;
    localparam logic [1:0] PH_DOWN = 2'b10;
    localparam logic [1:0] PH_BOT  = 2'b11;

    typedef enum logic [1:0] {
        ST_UP   = PH_UP,
        ST_TOP  = PH_TOP,
        ST_DOWN = PH_DOWN,
        ST_BOT  = PH_BOT
    } phase_e;

endpackage

// File: rtl/pwm_breather_if.sv
// rtl/pwm_breather_if.sv - count input and breathing-LED outputs of pwm_breather
interface pwm_breather_if
    import breather_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DUTY_W = DUTY_W_DEF
);
    logic              ena;
    logic [CNT_W-1:0]  currentCount;
    logic              pwm_out;
    logic [DUTY_W-1:0] duty;
    logic [1:0]        phase;
    logic              ramp_done;

    modport master (
        output ena,
        output currentCount,
        input  pwm_out,
        input  duty,
        input  phase,
        input  ramp_done
    );

    modport slave (
        input  ena,
        input  currentCount,
        output pwm_out,
        output duty,
        output phase,
        output ramp_done
    );
endinterface

// File: rtl/rise_tick.sv
// rtl/rise_tick.sv - one-cycle tick on each rising edge of a count bit
module rise_tick (
    input  logic clk,
    input  logic rst,
    input  logic bit_i,
    output logic tick_o
);
    logic prev_q;

    // Follow the bit every cycle, reset included, so a bit already high at release is not an edge.
    always_ff @(posedge clk) begin
        prev_q <= bit_i;
    end

    assign tick_o = bit_i & ~prev_q & ~rst;
endmodule

// File: rtl/pwm_breather.sv
// rtl/pwm_breather.sv - breathing LED PWM driven by the shared count; PWM_BREATHER_GAMMA_EN adds squared duty
module pwm_breather
    import breather_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int DUTY_W     = DUTY_W_DEF,
    parameter int STEP_BIT   = 11,
    parameter int HOLD_STEPS = 32
) (
    input  logic         clk,
    input  logic         rst,
    pwm_breather_if.slave bus
);
    localparam int                HOLD_W    = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [DUTY_W-1:0] DUTY_TOP  = '1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    phase_e              state_q;
    logic [DUTY_W-1:0]   duty_q;
    logic [HOLD_W-1:0]   hold_q;
    logic                ramp_done_q;
    logic                pwm_q;
    logic                pwm_d;
    logic                tick;
    logic [DUTY_W-1:0]   eff_duty;
    logic                unused_cnt_bits;

    // Only the step bit and the low DUTY_W bits matter here.
    assign unused_cnt_bits = ^bus.currentCount;

    rise_tick u_rise_tick (
        .clk    (clk),
        .rst    (rst),
        .bit_i  (bus.currentCount[STEP_BIT]),
        .tick_o (tick)
    );

`ifdef PWM_BREATHER_GAMMA_EN
    logic [2*DUTY_W-1:0] duty_sq;
    assign duty_sq  = {{DUTY_W{1'b0}}, duty_q} * {{DUTY_W{1'b0}}, duty_q};
    assign eff_duty = duty_sq[2*DUTY_W-1:DUTY_W];
`else
    assign eff_duty = duty_q;
`endif

    assign pwm_d = bus.ena & (bus.currentCount[DUTY_W-1:0] < eff_duty);

    // Breath sequencer: ramp up, hold, ramp down, hold; advances only on an enabled tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_UP;
            duty_q      <= '0;
            hold_q      <= '0;
            ramp_done_q <= 1'b0;
        end else begin
            ramp_done_q <= 1'b0;
            if (tick && bus.ena) begin
                case (state_q)
                    ST_UP: begin
                        if (duty_q >= DUTY_TOP - DUTY_W'(1)) begin
                            duty_q  <= DUTY_TOP;
                            hold_q  <= '0;
                            state_q <= ST_TOP;
                        end else begin
                            duty_q <= duty_q + DUTY_W'(1);
                        end
                    end
                    ST_TOP: begin
                        if (hold_q == HOLD_LAST) begin
                            hold_q  <= '0;
                            state_q <= ST_DOWN;
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                    ST_DOWN: begin
                        if (duty_q <= DUTY_W'(1)) begin
                            duty_q  <= '0;
                            hold_q  <= '0;
                            state_q <= ST_BOT;
                        end else begin
                            duty_q <= duty_q - DUTY_W'(1);
                        end
                    end
                    ST_BOT: begin
                        if (hold_q == HOLD_LAST) begin
                            hold_q      <= '0;
                            state_q     <= ST_UP;
                            ramp_done_q <= 1'b1;
                        end else begin
                            hold_q <= hold_q + HOLD_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_UP;
                    end
                endcase
            end
        end
    end

    // PWM compare, registered; disable forces it low from the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign bus.pwm_out   = pwm_q;
    assign bus.duty      = duty_q;
    assign bus.phase     = state_q;
    assign bus.ramp_done = ramp_done_q;
endmodule

// File: tb/tb_pwm_breather.sv
// tb/tb_pwm_breather.sv - self-checking bench for pwm_breather
module tb_pwm_breather;
    localparam int SB = 3;
    localparam int H  = 4;
    localparam int P  = 2 * 255 + 2 * H;
`ifdef PWM_BREATHER_GAMMA_EN
    localparam int W10 = 0, W128 = 64, W255 = 254;
`else
    localparam int W10 = 10, W128 = 128, W255 = 255;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_breather_if #(.CNT_W(16), .DUTY_W(8)) bus_if ();

    pwm_breather #(.CNT_W(16), .DUTY_W(8), .STEP_BIT(SB), .HOLD_STEPS(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: position within one breath of P enabled ticks.
    int   pos = 0;
    logic m_prev = 1'b0;
    logic m_pwm = 1'b0;
    logic m_rd = 1'b0;
    int   n_ticks = 0;
    int   rd_seen, dmax, max_jump, last_duty, pwm_hi;
    logic [15:0] cnt_v;

    function automatic int duty_of(input int p);
        if (p < 255)     return p;
        if (p < 255 + H) return 255;
        if (p < 510 + H) return 255 - (p - 255 - H);
        return 0;
    endfunction

    function automatic int phase_of(input int p);
        if (p < 255)     return 0;
        if (p < 255 + H) return 1;
        if (p < 510 + H) return 2;
        return 3;
    endfunction

    function automatic int eff_of(input int d);
`ifdef PWM_BREATHER_GAMMA_EN
        return (d * d) / 256;
`else
        return d;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step_cycle(input logic r, input logic e, input logic [15:0] c);
        logic tk;
        int   d;
        rst = r;
        bus_if.ena = e;
        bus_if.currentCount = c;
        @(posedge clk);
        tk = c[SB] && !m_prev;
        m_prev = c[SB];
        if (r) begin
            pos = 0; m_pwm = 1'b0; m_rd = 1'b0;
        end else begin
            m_pwm = e && (int'(c[7:0]) < eff_of(duty_of(pos)));
            m_rd = 1'b0;
            if (tk && e) begin
                if (pos == P - 1) m_rd = 1'b1;
                pos = (pos + 1) % P;
                n_ticks++;
            end
        end
        @(negedge clk);
        chk("duty", int'(bus_if.duty), duty_of(pos));
        chk("phase", int'(bus_if.phase), phase_of(pos));
        chk("pwm_out", int'(bus_if.pwm_out), int'(m_pwm));
        chk("ramp_done", int'(bus_if.ramp_done), int'(m_rd));
        d = int'(bus_if.duty);
        if (bus_if.ramp_done) rd_seen++;
        if (bus_if.pwm_out) pwm_hi++;
        if (d > dmax) dmax = d;
        if (d - last_duty > max_jump) max_jump = d - last_duty;
        if (last_duty - d > max_jump) max_jump = last_duty - d;
        last_duty = d;
    endtask

    task automatic run_ticks(input int n);
        int target;
        target = n_ticks + n;
        for (int k = 0; k < 32 * n + 32 && n_ticks < target; k++) begin
            step_cycle(1'b0, 1'b1, cnt_v);
            cnt_v++;
        end
        chk("run_ticks_reached", n_ticks, target);
    endtask

    // Sweep all 256 low-byte values without a rising step bit so duty stays put.
    task automatic window(input string name, input int exp);
        pwm_hi = 0;
        for (int half = 1; half >= 0; half--)
            for (int v = 0; v < 256; v++)
                if (((v >> SB) & 1) == half) step_cycle(1'b0, 1'b1, 16'(v));
        chk(name, pwm_hi, exp);
        cnt_v = {cnt_v[15:4] + 12'd1, 4'd0};
    endtask

    typedef struct {
        logic        r;
        logic        e;
        logic [15:0] c;
        int          duty;
        logic        pwm;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic [15:0] c,
                                input int d, input logic p);
        vec_t v;
        v.r = r; v.e = e; v.c = c; v.duty = d; v.pwm = p;
        return v;
    endfunction

    vec_t vt[20];

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus_if.ena = 1'b0;
        bus_if.currentCount = 16'h0;
        @(negedge clk);

        vt[0]  = mk(1, 1, 16'h0FFF, 0, 0);
        vt[1]  = mk(1, 1, 16'h0FFF, 0, 0);
        vt[2]  = mk(1, 1, 16'h0FFF, 0, 0);
        vt[3]  = mk(0, 1, 16'h0FFF, 0, 0);
        vt[4]  = mk(0, 1, 16'h0FFF, 0, 0);
        vt[5]  = mk(0, 1, 16'h0FF0, 0, 0);
        vt[6]  = mk(0, 1, 16'h0FF8, 1, 0);
        vt[7]  = mk(0, 1, 16'h0000, 1, 1);
        vt[8]  = mk(0, 1, 16'h0001, 1, 0);
        vt[9]  = mk(0, 1, 16'h0808, 2, 0);
        vt[10] = mk(0, 1, 16'h0000, 2, 1);
        vt[11] = mk(0, 1, 16'h0005, 2, 0);
        vt[12] = mk(0, 1, 16'h0001, 2, 1);
        vt[13] = mk(0, 1, 16'h000C, 3, 0);
        vt[14] = mk(0, 0, 16'h0000, 3, 0);
        vt[15] = mk(0, 0, 16'h0008, 3, 0);
        vt[16] = mk(0, 1, 16'h0009, 3, 0);
        vt[17] = mk(0, 1, 16'h0000, 3, 1);
        vt[18] = mk(1, 1, 16'h0008, 0, 0);
        vt[19] = mk(0, 1, 16'h0008, 0, 0);

        foreach (vt[i]) begin
            step_cycle(vt[i].r, vt[i].e, vt[i].c);
            chk($sformatf("vec%0d_duty", i), int'(bus_if.duty), vt[i].duty);
            chk($sformatf("vec%0d_phase", i), int'(bus_if.phase), 0);
            chk($sformatf("vec%0d_ramp_done", i), int'(bus_if.ramp_done), 0);
`ifndef PWM_BREATHER_GAMMA_EN
            chk($sformatf("vec%0d_pwm", i), int'(bus_if.pwm_out), int'(vt[i].pwm));
`endif
        end

        // PWM and full breath from a fresh reset with a free-running count.
        cnt_v = 16'h0;
        step_cycle(1'b1, 1'b1, cnt_v);
        step_cycle(1'b1, 1'b1, cnt_v);
        rd_seen = 0; dmax = 0; max_jump = 0; last_duty = 0;
        run_ticks(10);
        chk("pwm_test_duty", int'(bus_if.duty), 10);
        window("pwm_high_at_10", W10);
        run_ticks(118);
        chk("duty_128", int'(bus_if.duty), 128);
        window("pwm_high_at_128", W128);
        run_ticks(127);
        chk("duty_255", int'(bus_if.duty), 255);
        chk("phase_top", int'(bus_if.phase), 1);
        window("pwm_high_at_255", W255);
        run_ticks(P - 255);
        chk("breath_end_phase", int'(bus_if.phase), 0);
        chk("breath_end_duty", int'(bus_if.duty), 0);
        chk("breath_ramp_done_cycles", rd_seen, 1);
        chk("breath_peak", dmax, 255);
        chk("breath_max_jump", max_jump, 1);

        // Enable freeze at duty 100.
        run_ticks(100);
        chk("freeze_start_duty", int'(bus_if.duty), 100);
        pwm_hi = 0;
        for (int k = 0; k < 800; k++) begin
            step_cycle(1'b0, 1'b0, cnt_v);
            cnt_v++;
        end
        for (int k = 0; k < 32 && cnt_v[3:0] != 4'd9; k++) begin
            step_cycle(1'b0, 1'b0, cnt_v);
            cnt_v++;
        end
        chk("freeze_duty", int'(bus_if.duty), 100);
        chk("freeze_pwm_high", pwm_hi, 0);
        step_cycle(1'b0, 1'b1, cnt_v);
        cnt_v++;
        chk("reenable_no_tick", int'(bus_if.duty), 100);
        run_ticks(1);
        chk("reenable_first_tick", int'(bus_if.duty), 101);

        // Upstream counter drops to zero while the step bit is high.
        step_cycle(1'b0, 1'b1, 16'h0808);
        chk("drop_pre", int'(bus_if.duty), 101);
        step_cycle(1'b0, 1'b1, 16'h0000);
        chk("drop_no_tick", int'(bus_if.duty), 101);
        cnt_v = 16'h0001;
        run_ticks(1);
        chk("drop_next_edge", int'(bus_if.duty), 102);

        // Random count jumps, enable and reset against the reference.
        for (int k = 0; k < 3000; k++) begin
            logic        r, e;
            logic [15:0] c;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) < 8) begin
                cnt_v++;
                c = cnt_v;
            end else begin
                c = 16'($urandom);
                cnt_v = c;
            end
            step_cycle(r, e, c);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
